// File: rtl/io_pkg.sv
// Shared IO-peripheral definitions: register addresses, LED width and the
// active-low hex-to-seven-segment lookup table.
package io_pkg;

  localparam logic [1:0] ADDR_LED      = 2'd0;
  localparam logic [1:0] ADDR_SEG_DATA = 2'd1;
  localparam logic [1:0] ADDR_SEG_MASK = 2'd2;

  localparam int LED_W = 17;

  // Segment order {g,f,e,d,c,b,a}; a 0 lights the segment.
  localparam logic [6:0] HEX7_TABLE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/led_seg_out_if.sv
// CPU IO-store/load bus between the IO decoder (master) and the
// LED/seven-segment output peripheral (slave).
interface led_seg_out_if;

  logic        io_write;
  logic        io_read;
  logic [1:0]  io_addr;
  logic [31:0] io_wdata;
  logic [31:0] io_rdata;

  modport master (
    output io_write,
    output io_read,
    output io_addr,
    output io_wdata,
    input  io_rdata
  );

  modport slave (
    input  io_write,
    input  io_read,
    input  io_addr,
    input  io_wdata,
    output io_rdata
  );

endinterface

// File: rtl/seg7_hex_decode.sv
// Combinational hex digit to active-low {g..a} segment pattern.
module seg7_hex_decode
  import io_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = HEX7_TABLE[hex];

endmodule

// File: rtl/led_seg_out.sv
// Memory-mapped LED and 8-digit common-anode seven-segment output block.
// Define SEG_LZB_EN to enable leading-zero blanking on the display.
module led_seg_out
  import io_pkg::*;
#(
  parameter int SCAN_DIV = 100000,
  parameter int DIG_N    = 8
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  led_seg_out_if.slave       bus,
  output logic [LED_W-1:0]   led,
  output logic [7:0]         seg_an,
  output logic [7:0]         seg_ca
);

  localparam int              PW         = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0]   PRESC_LAST = PW'(SCAN_DIV - 1);
  localparam logic [2:0]      LAST_DIG   = 3'(DIG_N - 1);

  logic [LED_W-1:0] led_reg;
  logic [31:0]      seg_data_reg;
  logic [7:0]       seg_mask_reg;
  logic [31:0]      rdata_reg;
  logic [31:0]      rdata_next;
  logic [PW-1:0]    presc_reg;
  logic [2:0]       dig_idx_reg;
  logic [7:0]       seg_an_reg;
  logic [7:0]       seg_ca_reg;
  logic [7:0]       seg_an_next;
  logic [7:0]       seg_ca_next;
  logic [7:0]       digit_en;
  logic [3:0]       cur_nibble;
  logic [6:0]       cur_seg;

  // Register file
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      led_reg      <= '0;
      seg_data_reg <= '0;
      seg_mask_reg <= 8'hFF;
    end else if (bus.io_write) begin
      case (bus.io_addr)
        ADDR_LED:      led_reg      <= bus.io_wdata[LED_W-1:0];
        ADDR_SEG_DATA: seg_data_reg <= bus.io_wdata;
        ADDR_SEG_MASK: seg_mask_reg <= bus.io_wdata[7:0];
        default:       ;
      endcase
    end
  end

  // Read mux samples pre-write register values, so a same-cycle
  // read/write of one address returns the old contents.
  always_comb begin
    rdata_next = '0;
    case (bus.io_addr)
      ADDR_LED:      rdata_next[LED_W-1:0] = led_reg;
      ADDR_SEG_DATA: rdata_next            = seg_data_reg;
      ADDR_SEG_MASK: rdata_next[7:0]       = seg_mask_reg;
      default:       rdata_next            = '0;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rdata_reg <= '0;
    end else if (bus.io_read) begin
      rdata_reg <= rdata_next;
    end
  end

  assign bus.io_rdata = rdata_reg;
  assign led          = led_reg;

  // Prescaler and digit index
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      presc_reg   <= '0;
      dig_idx_reg <= '0;
    end else if (presc_reg == PRESC_LAST) begin
      presc_reg   <= '0;
      dig_idx_reg <= (dig_idx_reg == LAST_DIG) ? 3'd0 : dig_idx_reg + 3'd1;
    end else begin
      presc_reg   <= presc_reg + PW'(1);
    end
  end

`ifdef SEG_LZB_EN
  // zero_run[i] is set when digit i and every digit above it are zero.
  logic [DIG_N:0] zero_run;
  assign zero_run[DIG_N] = 1'b1;
  for (genvar gi = 0; gi < DIG_N; gi++) begin : g_lzb
    assign zero_run[gi] = (seg_data_reg[4*gi +: 4] == 4'h0) && zero_run[gi+1];
  end

  for (genvar gi = 0; gi < 8; gi++) begin : g_en
    if (gi == 0) begin : g_d0
      assign digit_en[gi] = seg_mask_reg[gi];
    end else if (gi < DIG_N) begin : g_dn
      assign digit_en[gi] = seg_mask_reg[gi] && !zero_run[gi];
    end else begin : g_off
      assign digit_en[gi] = 1'b0;
    end
  end
`else
  for (genvar gi = 0; gi < 8; gi++) begin : g_en
    if (gi < DIG_N) begin : g_dn
      assign digit_en[gi] = seg_mask_reg[gi];
    end else begin : g_off
      assign digit_en[gi] = 1'b0;
    end
  end
`endif

  assign cur_nibble = seg_data_reg[{dig_idx_reg, 2'b00} +: 4];

  seg7_hex_decode u_hex (
    .hex (cur_nibble),
    .seg (cur_seg)
  );

  // Blanked slots keep the scan cadence; only the pins go dark.
  always_comb begin
    seg_an_next = 8'hFF;
    seg_ca_next = 8'hFF;
    if (digit_en[dig_idx_reg]) begin
      seg_an_next = ~(8'h01 << dig_idx_reg);
      seg_ca_next = {1'b1, cur_seg};
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      seg_an_reg <= 8'hFF;
      seg_ca_reg <= 8'hFF;
    end else begin
      seg_an_reg <= seg_an_next;
      seg_ca_reg <= seg_ca_next;
    end
  end

  assign seg_an = seg_an_reg;
  assign seg_ca = seg_ca_reg;

endmodule

// File: tb/tb_led_seg_out.sv
// Directed self-checking bench for led_seg_out with a 4-cycle digit slot.
module tb_led_seg_out;
  import io_pkg::*;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [LED_W-1:0] led;
  logic [7:0]       seg_an;
  logic [7:0]       seg_ca;

  int vectors = 0;
  int errors  = 0;
  int edge_n  = 0;

  // Expected seg_ca per digit for seg_data = 32'h1234_ABCF.
  logic [7:0] ca_1234 [8] = '{8'h8E, 8'hC6, 8'h83, 8'h88, 8'h99, 8'hB0, 8'hA4, 8'hF9};

  led_seg_out_if bus ();

  led_seg_out #(
    .SCAN_DIV (4),
    .DIG_N    (8)
  ) dut (
    .sys_clk   (clk),
    .sys_rst_n (rst_n),
    .bus       (bus),
    .led       (led),
    .seg_an    (seg_an),
    .seg_ca    (seg_ca)
  );

  always #5 clk = ~clk;

  // Rising edges since the last reset release; slot = (edge_n-1)/4.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) edge_n <= 0;
    else        edge_n <= edge_n + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.io_write = 1'b1;
    bus.io_addr  = a;
    bus.io_wdata = d;
    @(negedge clk);
    bus.io_write = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    bus.io_read = 1'b1;
    bus.io_addr = a;
    @(negedge clk);
    bus.io_read = 1'b0;
  endtask

  function automatic bit an_legal(input logic [7:0] an);
    return (an == 8'hFF) || ($countones(~an) == 1);
  endfunction

  task automatic test_reset;
    rst_n = 1'b0;
    bus.io_write = 1'b0;
    bus.io_read  = 1'b0;
    bus.io_addr  = 2'd0;
    bus.io_wdata = 32'h0;
    repeat (2) @(negedge clk);
    vectors++; if (led !== 17'h0) begin errors++; $display("FAIL reset_led: got %h expected %h", led, 17'h0); end
    vectors++; if (seg_an !== 8'hFF) begin errors++; $display("FAIL reset_an: got %h expected %h", seg_an, 8'hFF); end
    vectors++; if (seg_ca !== 8'hFF) begin errors++; $display("FAIL reset_ca: got %h expected %h", seg_ca, 8'hFF); end
    vectors++; if (bus.io_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected %h", bus.io_rdata, 32'h0); end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (seg_an !== 8'hFE) begin errors++; $display("FAIL release_an: got %h expected %h", seg_an, 8'hFE); end
    vectors++; if (seg_ca !== 8'hC0) begin errors++; $display("FAIL release_ca: got %h expected %h", seg_ca, 8'hC0); end
    $display("reset: led=%h an=%h ca=%h", led, seg_an, seg_ca);
  endtask

  task automatic test_scan;
    int d;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wr(ADDR_SEG_DATA, 32'h1234_ABCF);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      d = ((edge_n - 1) / 4) % 8;
      vectors++; if (!an_legal(seg_an)) begin errors++; $display("FAIL scan_onehot: got %h expected one-hot-low or FF", seg_an); end
      vectors++; if (seg_an !== ~(8'h01 << d)) begin errors++; $display("FAIL scan_an d%0d: got %h expected %h", d, seg_an, ~(8'h01 << d)); end
      vectors++; if (seg_ca !== ca_1234[d]) begin errors++; $display("FAIL scan_ca d%0d: got %h expected %h", d, seg_ca, ca_1234[d]); end
    end
    $display("scan: 36 cycles of 1234ABCF checked");
  endtask

  task automatic test_mask;
    int d;
    wr(ADDR_SEG_MASK, 32'h0F);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      d = ((edge_n - 1) / 4) % 8;
      vectors++; if (!an_legal(seg_an)) begin errors++; $display("FAIL mask_onehot: got %h expected one-hot-low or FF", seg_an); end
      if (d < 4) begin
        vectors++; if (seg_an !== ~(8'h01 << d)) begin errors++; $display("FAIL mask_an d%0d: got %h expected %h", d, seg_an, ~(8'h01 << d)); end
        vectors++; if (seg_ca !== ca_1234[d]) begin errors++; $display("FAIL mask_ca d%0d: got %h expected %h", d, seg_ca, ca_1234[d]); end
      end else begin
        vectors++; if (seg_an !== 8'hFF) begin errors++; $display("FAIL mask_an_blank d%0d: got %h expected FF", d, seg_an); end
        vectors++; if (seg_ca !== 8'hFF) begin errors++; $display("FAIL mask_ca_blank d%0d: got %h expected FF", d, seg_ca); end
      end
    end
    $display("mask: 36 cycles with mask 0F checked");
  endtask

  task automatic test_led_rw;
    wr(ADDR_LED, 32'hFFFF_FFFF);
    vectors++; if (led !== 17'h1FFFF) begin errors++; $display("FAIL led_write: got %h expected %h", led, 17'h1FFFF); end
    rd(ADDR_LED);
    vectors++; if (bus.io_rdata !== 32'h0001_FFFF) begin errors++; $display("FAIL led_read: got %h expected %h", bus.io_rdata, 32'h0001_FFFF); end
    @(negedge clk);
    vectors++; if (bus.io_rdata !== 32'h0001_FFFF) begin errors++; $display("FAIL rdata_hold: got %h expected %h", bus.io_rdata, 32'h0001_FFFF); end
    $display("led_rw: led=%h rdata=%h", led, bus.io_rdata);
  endtask

  task automatic test_simultaneous;
    bus.io_write = 1'b1;
    bus.io_read  = 1'b1;
    bus.io_addr  = ADDR_SEG_DATA;
    bus.io_wdata = 32'h55;
    @(negedge clk);
    bus.io_write = 1'b0;
    bus.io_read  = 1'b0;
    vectors++; if (bus.io_rdata !== 32'h1234_ABCF) begin errors++; $display("FAIL rw_old: got %h expected %h", bus.io_rdata, 32'h1234_ABCF); end
    rd(ADDR_SEG_DATA);
    vectors++; if (bus.io_rdata !== 32'h55) begin errors++; $display("FAIL rw_new: got %h expected %h", bus.io_rdata, 32'h55); end
    wr(2'd3, 32'hDEAD_BEEF);
    rd(2'd3);
    vectors++; if (bus.io_rdata !== 32'h0) begin errors++; $display("FAIL addr3_read: got %h expected %h", bus.io_rdata, 32'h0); end
    rd(ADDR_LED);
    vectors++; if (bus.io_rdata !== 32'h0001_FFFF) begin errors++; $display("FAIL addr3_led: got %h expected %h", bus.io_rdata, 32'h0001_FFFF); end
    rd(ADDR_SEG_DATA);
    vectors++; if (bus.io_rdata !== 32'h55) begin errors++; $display("FAIL addr3_data: got %h expected %h", bus.io_rdata, 32'h55); end
    rd(ADDR_SEG_MASK);
    vectors++; if (bus.io_rdata !== 32'h0F) begin errors++; $display("FAIL addr3_mask: got %h expected %h", bus.io_rdata, 32'h0F); end
    vectors++; if (led !== 17'h1FFFF) begin errors++; $display("FAIL addr3_ledpin: got %h expected %h", led, 17'h1FFFF); end
    $display("simultaneous: rdata=%h led=%h", bus.io_rdata, led);
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++; if (led !== 17'h0) begin errors++; $display("FAIL midrst_led: got %h expected %h", led, 17'h0); end
    vectors++; if (seg_an !== 8'hFF) begin errors++; $display("FAIL midrst_an: got %h expected %h", seg_an, 8'hFF); end
    vectors++; if (seg_ca !== 8'hFF) begin errors++; $display("FAIL midrst_ca: got %h expected %h", seg_ca, 8'hFF); end
    vectors++; if (bus.io_rdata !== 32'h0) begin errors++; $display("FAIL midrst_rdata: got %h expected %h", bus.io_rdata, 32'h0); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    vectors++; if (seg_an !== 8'hFE) begin errors++; $display("FAIL midrst_d0_an: got %h expected %h", seg_an, 8'hFE); end
    vectors++; if (seg_ca !== 8'hC0) begin errors++; $display("FAIL midrst_d0_ca: got %h expected %h", seg_ca, 8'hC0); end
    repeat (4) @(negedge clk);
    vectors++; if (seg_an !== 8'hFD) begin errors++; $display("FAIL midrst_d1_an: got %h expected %h", seg_an, 8'hFD); end
    $display("reset_mid: an=%h ca=%h", seg_an, seg_ca);
  endtask

  task automatic test_lzb;
    int d;
    logic [7:0] exp_an;
    logic [7:0] exp_ca;
    wr(ADDR_SEG_DATA, 32'h0000_00A0);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      d = ((edge_n - 1) / 4) % 8;
      exp_an = ~(8'h01 << d);
      exp_ca = (d == 1) ? 8'h88 : 8'hC0;
`ifdef SEG_LZB_EN
      if (d >= 2) begin
        exp_an = 8'hFF;
        exp_ca = 8'hFF;
      end
`endif
      vectors++; if (!an_legal(seg_an)) begin errors++; $display("FAIL lzb_onehot: got %h expected one-hot-low or FF", seg_an); end
      vectors++; if (seg_an !== exp_an) begin errors++; $display("FAIL lzb_a0_an d%0d: got %h expected %h", d, seg_an, exp_an); end
      vectors++; if (seg_ca !== exp_ca) begin errors++; $display("FAIL lzb_a0_ca d%0d: got %h expected %h", d, seg_ca, exp_ca); end
    end
    wr(ADDR_SEG_DATA, 32'h0);
    for (int k = 0; k < 36; k++) begin
      @(negedge clk);
      d = ((edge_n - 1) / 4) % 8;
      exp_an = ~(8'h01 << d);
      exp_ca = 8'hC0;
`ifdef SEG_LZB_EN
      if (d >= 1) begin
        exp_an = 8'hFF;
        exp_ca = 8'hFF;
      end
`endif
      vectors++; if (seg_an !== exp_an) begin errors++; $display("FAIL lzb_zero_an d%0d: got %h expected %h", d, seg_an, exp_an); end
      vectors++; if (seg_ca !== exp_ca) begin errors++; $display("FAIL lzb_zero_ca d%0d: got %h expected %h", d, seg_ca, exp_ca); end
    end
    $display("lzb: data A0 and 0 scanned");
  endtask

  initial begin
    bus.io_write = 1'b0;
    bus.io_read  = 1'b0;
    bus.io_addr  = 2'd0;
    bus.io_wdata = 32'h0;
    test_reset();
    test_scan();
    test_mask();
    test_led_rw();
    test_simultaneous();
    test_reset_mid();
    test_lzb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
